// File: rtl/siso_frame_rx.sv
// Serial frame receiver for the SISO shift-register stream: start/data/parity/stop
// framing, error pulses, and a one-entry valid/ready output buffer.
module siso_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic ParityTarget = (ODD_PARITY != 0);
  localparam bit HasParity = (PARITY_EN != 0);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              parity_bad;
  logic              buf_free;

  // Without a parity bit there is nothing to mismatch.
  assign parity_bad = HasParity && ((^{shift_q, par_q}) != ParityTarget);
  // A transfer in this cycle frees the slot for a word loading in the same cycle.
  assign buf_free   = !valid_q || data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;

      if (valid_q && data_ready) begin
        valid_q <= 1'b0;
      end

      if (bit_en) begin
        unique case (state_q)
          StIdle: begin
            if (serial_in) begin
              state_q <= StData;
              cnt_q   <= '0;
            end
          end
          StData: begin
            shift_q <= {shift_q[DATA_W-2:0], serial_in};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LastBit) begin
              state_q <= HasParity ? StParity : StStop;
            end
          end
          StParity: begin
            par_q   <= serial_in;
            state_q <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (serial_in) begin
              frame_err_q <= 1'b1;
            end else if (parity_bad) begin
              parity_err_q <= 1'b1;
            end else if (buf_free) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != StIdle);
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
